// File: rtl/seg7_pkg.sv
// Shared constants for the six-digit multiplexed display: active-low segment
// codes (bit order g..a) and the all-digits-off select pattern.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [5:0] DIG_OFF = 6'h3F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-decimal
// nibbles show a dash rather than garbage so a bad time word is visible.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Six-digit common-anode scan driver for the hh:mm:ss clock: per-frame
// snapshot, dead time at each slot start, per-digit blink and colon dots.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int DEAD_CYC  = 500,
  parameter int BLINK_DIV = 83
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] time_bcd,
  input  logic [5:0]  blink_mask,
  input  logic        colon_on,
  output logic [5:0]  dig_sel,
  output logic [7:0]  seg
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0]  DEAD_LIM   = SCAN_W'(DEAD_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scanCnt_q, scanCnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic               blinkPhase_q, blinkPhase_d;
  logic [23:0]        shadow_q, shadow_d;
  logic               active_q, active_d;
  logic [5:0]         digSel_q, digSel_d;
  logic [7:0]         seg_q, seg_d;

  logic        slotEnd;
  logic        firstCycle;
  logic [23:0] frameWord;
  logic [3:0]  nibble;
  logic        blinkSel;
  logic        dpSlot;
  logic [6:0]  digitCode;

  assign slotEnd    = (scanCnt_q == SCAN_LAST);
  assign firstCycle = en & ~active_q;
  // On the enabling edge the shadow is still stale, so read the word being captured.
  assign frameWord  = firstCycle ? time_bcd : shadow_q;

  always_comb begin
    nibble   = 4'h0;
    blinkSel = 1'b0;
    dpSlot   = 1'b0;
    case (idx_q)
      3'd0: begin nibble = frameWord[3:0];   blinkSel = blink_mask[0]; end
      3'd1: begin nibble = frameWord[7:4];   blinkSel = blink_mask[1]; end
      3'd2: begin nibble = frameWord[11:8];  blinkSel = blink_mask[2]; dpSlot = 1'b1; end
      3'd3: begin nibble = frameWord[15:12]; blinkSel = blink_mask[3]; end
      3'd4: begin nibble = frameWord[19:16]; blinkSel = blink_mask[4]; dpSlot = 1'b1; end
      3'd5: begin nibble = frameWord[23:20]; blinkSel = blink_mask[5]; end
      default: ;
    endcase
  end

  bcd_to_seg7 u_dec (
    .nibble_i (nibble),
    .seg_o    (digitCode)
  );

  always_comb begin
    scanCnt_d    = scanCnt_q;
    idx_d        = idx_q;
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    digSel_d     = DIG_OFF;
    seg_d        = {1'b1, SEG_BLANK};

    if (!en) begin
      scanCnt_d    = '0;
      idx_d        = 3'd0;
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b0;
      active_d     = 1'b0;
    end else begin
      active_d  = 1'b1;
      scanCnt_d = slotEnd ? '0 : scanCnt_q + 1'b1;

      if (slotEnd) begin
        idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        if (blinkCnt_q == BLINK_LAST) begin
          blinkCnt_d   = '0;
          blinkPhase_d = ~blinkPhase_q;
        end else begin
          blinkCnt_d = blinkCnt_q + 1'b1;
        end
      end

      if (firstCycle || (slotEnd && idx_q == 3'd5)) begin
        shadow_d = time_bcd;
      end

      if (scanCnt_q >= DEAD_LIM) begin
        digSel_d = ~(6'b000001 << idx_q);
        if (!(blinkSel && blinkPhase_q)) begin
          seg_d = {~(colon_on & dpSlot), digitCode};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scanCnt_q    <= '0;
      idx_q        <= 3'd0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      shadow_q     <= '0;
      active_q     <= 1'b0;
      digSel_q     <= DIG_OFF;
      seg_q        <= 8'hFF;
    end else begin
      scanCnt_q    <= scanCnt_d;
      idx_q        <= idx_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      digSel_q     <= digSel_d;
      seg_q        <= seg_d;
    end
  end

  assign dig_sel = digSel_q;
  assign seg     = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a short scan (4 cycles/slot,
// 1 dead cycle, blink toggles every 2 slots).
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic        en;
  logic [23:0] time_bcd;
  logic [5:0]  blink_mask;
  logic        colon_on;
  logic [5:0]  dig_sel;
  logic [7:0]  seg;

  int assertCount = 0;
  int failCount   = 0;

  logic [5:0] digTab [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  seg7_scan_driver #(
    .SCAN_DIV  (4),
    .DEAD_CYC  (1),
    .BLINK_DIV (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .time_bcd   (time_bcd),
    .blink_mask (blink_mask),
    .colon_on   (colon_on),
    .dig_sel    (dig_sel),
    .seg        (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land just after the edge to sample outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Park the scan with en low for one edge, then re-enable from digit 0.
  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; time_bcd = 24'h0; blink_mask = 6'h0; colon_on = 1'b0;
    tick();
    tick();
    assertCount++;
    if (dig_sel !== 6'h3F) begin
      failCount++;
      $display("[TB] FAIL reset_dig: got %h expected %h", dig_sel, 6'h3F);
    end
    assertCount++;
    if (seg !== 8'hFF) begin
      failCount++;
      $display("[TB] FAIL reset_seg: got %h expected %h", seg, 8'hFF);
    end
    rst = 1'b0;
    tick();
    assertCount++;
    if (dig_sel !== 6'h3F || seg !== 8'hFF) begin
      failCount++;
      $display("[TB] FAIL idle_disabled: got %h/%h expected 3f/ff", dig_sel, seg);
    end
  endtask

  task automatic test_scan();
    logic [7:0] expSeg [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [5:0] eDig;
    logic [7:0] eSeg;
    time_bcd = 24'h123456; colon_on = 1'b0; blink_mask = 6'h0;
    restart();
    for (int s = 0; s < 7; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        eDig = (c == 0) ? 6'h3F : digTab[s % 6];
        eSeg = (c == 0) ? 8'hFF : expSeg[s % 6];
        assertCount++;
        if (dig_sel !== eDig) begin
          failCount++;
          $display("[TB] FAIL scan_dig slot %0d cyc %0d: got %h expected %h", s, c, dig_sel, eDig);
        end
        assertCount++;
        if (seg !== eSeg) begin
          failCount++;
          $display("[TB] FAIL scan_seg slot %0d cyc %0d: got %h expected %h", s, c, seg, eSeg);
        end
      end
    end
  endtask

  task automatic test_anti_tear();
    logic [7:0] expSeg [12] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9,
                                8'h90, 8'h92, 8'h90, 8'h92, 8'hB0, 8'hA4};
    logic [7:0] eSeg;
    time_bcd = 24'h123456; colon_on = 1'b0; blink_mask = 6'h0;
    restart();
    for (int s = 0; s < 12; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        if (s == 3 && c == 0) time_bcd = 24'h235959;
        eSeg = (c == 0) ? 8'hFF : expSeg[s];
        assertCount++;
        if (seg !== eSeg) begin
          failCount++;
          $display("[TB] FAIL tear_seg slot %0d cyc %0d: got %h expected %h", s, c, seg, eSeg);
        end
      end
    end
  endtask

  task automatic test_colon();
    logic [7:0] expSeg [6] = '{8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0};
    time_bcd = 24'h000000; colon_on = 1'b1; blink_mask = 6'h0;
    restart();
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        if (c == 2) begin
          assertCount++;
          if (seg !== expSeg[s] || dig_sel !== digTab[s]) begin
            failCount++;
            $display("[TB] FAIL colon slot %0d: got %h/%h expected %h/%h", s, dig_sel, seg, digTab[s], expSeg[s]);
          end
        end
      end
    end
    colon_on = 1'b0;
  endtask

  task automatic test_blink();
    logic [7:0] normSeg [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic       blank;
    logic [7:0] eSeg;
    time_bcd = 24'h123456; colon_on = 1'b0; blink_mask = 6'b110000;
    restart();
    for (int s = 0; s < 24; s++) begin
      blank = ((s % 6) >= 4) && (((s / 2) % 2) == 1);
      for (int c = 1; c < 4; c++) begin
        if (c == 1) tick();
        tick();
        eSeg = blank ? 8'hFF : normSeg[s % 6];
        assertCount++;
        if (dig_sel !== digTab[s % 6]) begin
          failCount++;
          $display("[TB] FAIL blink_dig slot %0d cyc %0d: got %h expected %h", s, c, dig_sel, digTab[s % 6]);
        end
        assertCount++;
        if (seg !== eSeg) begin
          failCount++;
          $display("[TB] FAIL blink_seg slot %0d cyc %0d: got %h expected %h", s, c, seg, eSeg);
        end
      end
    end
    blink_mask = 6'h0;
  endtask

  task automatic test_invalid_and_enable();
    time_bcd = 24'h00000A; colon_on = 1'b0; blink_mask = 6'h0;
    restart();
    tick();
    tick();
    assertCount++;
    if (dig_sel !== 6'h3E || seg !== 8'hBF) begin
      failCount++;
      $display("[TB] FAIL dash: got %h/%h expected 3e/bf", dig_sel, seg);
    end
    en = 1'b0;
    tick();
    assertCount++;
    if (dig_sel !== 6'h3F || seg !== 8'hFF) begin
      failCount++;
      $display("[TB] FAIL en_off: got %h/%h expected 3f/ff", dig_sel, seg);
    end
    time_bcd = 24'h000007;
    en = 1'b1;
    tick();
    assertCount++;
    if (dig_sel !== 6'h3F || seg !== 8'hFF) begin
      failCount++;
      $display("[TB] FAIL reen_dead: got %h/%h expected 3f/ff", dig_sel, seg);
    end
    for (int c = 1; c < 4; c++) begin
      tick();
      assertCount++;
      if (dig_sel !== 6'h3E || seg !== 8'hF8) begin
        failCount++;
        $display("[TB] FAIL reen_d0 cyc %0d: got %h/%h expected 3e/f8", c, dig_sel, seg);
      end
    end
    tick();
    tick();
    assertCount++;
    if (dig_sel !== 6'h3D || seg !== 8'hC0) begin
      failCount++;
      $display("[TB] FAIL reen_d1: got %h/%h expected 3d/c0", dig_sel, seg);
    end
  endtask

  task automatic test_reset_mid();
    time_bcd = 24'h123456; colon_on = 1'b0; blink_mask = 6'h0;
    restart();
    for (int i = 0; i < 15; i++) tick();
    assertCount++;
    if (dig_sel !== 6'h37 || seg !== 8'hB0) begin
      failCount++;
      $display("[TB] FAIL pre_rst_d3: got %h/%h expected 37/b0", dig_sel, seg);
    end
    #2;
    rst = 1'b1;
    #1;
    assertCount++;
    if (dig_sel !== 6'h3F || seg !== 8'hFF) begin
      failCount++;
      $display("[TB] FAIL async_rst: got %h/%h expected 3f/ff", dig_sel, seg);
    end
    tick();
    rst = 1'b0;
    tick();
    assertCount++;
    if (dig_sel !== 6'h3F || seg !== 8'hFF) begin
      failCount++;
      $display("[TB] FAIL post_rst_dead: got %h/%h expected 3f/ff", dig_sel, seg);
    end
    for (int c = 1; c < 4; c++) begin
      tick();
      assertCount++;
      if (dig_sel !== 6'h3E || seg !== 8'h82) begin
        failCount++;
        $display("[TB] FAIL post_rst_d0 cyc %0d: got %h/%h expected 3e/82", c, dig_sel, seg);
      end
    end
    tick();
    tick();
    assertCount++;
    if (dig_sel !== 6'h3D || seg !== 8'h92) begin
      failCount++;
      $display("[TB] FAIL post_rst_d1: got %h/%h expected 3d/92", dig_sel, seg);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_anti_tear();
    test_colon();
    test_blink();
    test_invalid_and_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
